// File: rtl/harness_stream_controller_pkg.sv
// Shared definitions for the test-harness stream controller: byte width and FSM state encodings.
package harness_stream_controller_pkg;

    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned LAT_WIDTH  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_SEND  = 2'd3;

endpackage

// File: rtl/harness_hold_register.sv
// One-entry valid/ready buffer holding the next received byte until the controller issues it.
module harness_hold_register
    import harness_stream_controller_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  pop,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_full
);

    logic                  full_q, full_d;
    logic [BYTE_WIDTH-1:0] data_q, data_d;

    // Load and pop are mutually exclusive: load needs empty, pop is only issued while full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !full_q;
    assign out_data = data_q;
    assign out_full = full_q;

endmodule

// File: rtl/harness_stream_controller.sv
// Sequences one byte at a time from UART rx through replicate/processor to UART tx,
// guaranteeing exactly one transmitted byte per received byte.
module harness_stream_controller
    import harness_stream_controller_pkg::*;
#(
    parameter int unsigned PROCESSOR_LATENCY = 4,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BYTE_WIDTH-1:0]  rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [BYTE_WIDTH-1:0]  rep_data,
    output logic                   rep_valid,
    input  logic                   rep_ready,
    output logic                   proc_enable,
    input  logic [BYTE_WIDTH-1:0]  result_data,
    output logic [BYTE_WIDTH-1:0]  tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [COUNT_WIDTH-1:0] processed_count
);

    state_t                 state_q, state_d;
    logic [LAT_WIDTH-1:0]   lat_cnt_q, lat_cnt_d;
    logic [BYTE_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic                   hold_full;
    logic [BYTE_WIDTH-1:0]  hold_data;
    logic                   hold_pop;
    logic                   lat_done;
    logic                   tx_fire;

    harness_hold_register u_hold (
        .clock    (clock),
        .reset    (reset),
        .in_data  (rx_data),
        .in_valid (rx_valid),
        .in_ready (rx_ready),
        .pop      (hold_pop),
        .out_data (hold_data),
        .out_full (hold_full)
    );

    assign lat_done = (lat_cnt_q <= LAT_WIDTH'(1));
    assign tx_fire  = tx_valid_q && tx_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hold_full) state_d = ST_ISSUE;
            ST_ISSUE: if (proc_enable) state_d = ST_WAIT;
            ST_WAIT:  if (lat_done) state_d = ST_SEND;
            ST_SEND:  if (tx_fire) state_d = hold_full ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Enable rides the replicate handshake so the processor advances exactly once per byte.
    always_comb begin
        rep_valid   = (state_q == ST_ISSUE);
        rep_data    = hold_data;
        proc_enable = rep_valid && rep_ready;
        hold_pop    = proc_enable;
        lat_cnt_d   = lat_cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        count_d     = count_q;
        case (state_q)
            ST_ISSUE: begin
                if (proc_enable) lat_cnt_d = LAT_WIDTH'(PROCESSOR_LATENCY);
            end
            ST_WAIT: begin
                if (lat_done) begin
                    lat_cnt_d  = '0;
                    tx_data_d  = result_data;
                    tx_valid_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_WIDTH'(1);
                end
            end
            ST_SEND: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    count_d    = count_q + COUNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_cnt_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            lat_cnt_q  <= lat_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            count_q    <= count_d;
        end
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign processed_count = count_q;

endmodule

// File: tb/tb_harness_stream_controller.sv
// Directed bench for harness_stream_controller with a behavioural processor (result = byte ^ 8'h99).
module tb_harness_stream_controller;

    logic       clock;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rep_data;
    logic       rep_valid;
    logic       rep_ready;
    logic       proc_enable;
    logic [7:0] result_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] processed_count;

    int n_cmp = 0;
    int n_err = 0;

    int         en_count = 0;
    logic [7:0] en_age   = 8'hFF;
    logic [7:0] cur_byte = 8'h00;
    logic [3:0] prev_cnt = 4'd0;
    logic       saw_wrap = 1'b0;
    logic [7:0] txq[$];

    harness_stream_controller #(
        .PROCESSOR_LATENCY (4),
        .COUNT_WIDTH       (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rep_data        (rep_data),
        .rep_valid       (rep_valid),
        .rep_ready       (rep_ready),
        .proc_enable     (proc_enable),
        .result_data     (result_data),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .processed_count (processed_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Processor model: result is valid only in the cycle exactly 4 cycles after the enable beat.
    assign result_data = (en_age == 8'd4) ? (cur_byte ^ 8'h99) : 8'hEE;

    always @(negedge clock) begin
        if (proc_enable) begin
            en_count <= en_count + 1;
            en_age   <= 8'd0;
            cur_byte <= rep_data;
        end else if (en_age != 8'hFF) begin
            en_age <= en_age + 8'd1;
        end
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        prev_cnt <= processed_count;
        if (prev_cnt == 4'd15 && processed_count == 4'd0) saw_wrap <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_valid(input string tag, output int n);
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(tx_valid), 32'd1);
    endtask

    task automatic wait_txq(input int target, input string tag);
        int n = 0;
        while (txq.size() < target && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(txq.size()), 32'(target));
    endtask

    initial begin
        int         n;
        int         q0;
        int         e0;
        int         idx;
        int         errs;
        logic       acc;
        logic       saw_nr;
        logic [7:0] hold0;
        logic [7:0] arr3 [3];

        reset     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rep_ready = 1'b0;
        tx_ready  = 1'b0;
        arr3      = '{8'h01, 8'h02, 8'h03};

        // Reset state
        #2;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rep_valid", 32'(rep_valid), 32'd0);
        chk("rst_count", 32'(processed_count), 32'd0);
        do_reset();
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);

        // Test 1: asynchronous reset in SEND
        rep_ready = 1'b1;
        tx_ready  = 1'b0;
        send_byte(8'h77);
        wait_tx_valid("t1_in_send", n);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_tx_valid", 32'(tx_valid), 32'd0);
        chk("t1_tx_data", 32'(tx_data), 32'h00);
        chk("t1_rep_valid", 32'(rep_valid), 32'd0);
        chk("t1_rep_data", 32'(rep_data), 32'h00);
        chk("t1_proc_enable", 32'(proc_enable), 32'd0);
        chk("t1_count", 32'(processed_count), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("t1_rx_ready_after", 32'(rx_ready), 32'd1);
        chk("t1_count_after", 32'(processed_count), 32'd0);

        // Test 2: single byte, latency and result capture
        do_reset();
        rep_ready = 1'b1;
        tx_ready  = 1'b1;
        e0 = en_count;
        q0 = txq.size();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        chk("t2_rx_ready", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
        wait_tx_valid("t2_tx_valid", n);
        chk("t2_latency", 32'(n), 32'd6);
        chk("t2_tx_data", 32'(tx_data), 32'h3C);
        chk("t2_enables", 32'(en_count - e0), 32'd1);
        tick();
        chk("t2_tx_valid_clr", 32'(tx_valid), 32'd0);
        chk("t2_count", 32'(processed_count), 32'd1);
        chk("t2_txq", 32'(txq.size() - q0), 32'd1);

        // Test 3: back-to-back bytes with rx_valid held high
        do_reset();
        e0 = en_count;
        q0 = txq.size();
        idx = 0;
        saw_nr = 1'b0;
        n = 0;
        while (idx < 3 && n < 100) begin
            rx_valid = 1'b1;
            rx_data  = arr3[idx];
            if (!rx_ready) saw_nr = 1'b1;
            acc = rx_ready;
            tick();
            if (acc) idx++;
            n++;
        end
        rx_valid = 1'b0;
        wait_txq(q0 + 3, "t3_tx_bytes");
        chk("t3_rx_ready_dropped", 32'(saw_nr), 32'd1);
        chk("t3_byte0", 32'(txq[q0]), 32'h98);
        chk("t3_byte1", 32'(txq[q0 + 1]), 32'h9B);
        chk("t3_byte2", 32'(txq[q0 + 2]), 32'h9A);
        chk("t3_enables", 32'(en_count - e0), 32'd3);
        chk("t3_count", 32'(processed_count), 32'd3);

        // Test 4: tx_ready stall in SEND with a second byte buffered
        do_reset();
        tx_ready = 1'b0;
        q0 = txq.size();
        send_byte(8'h10);
        wait_tx_valid("t4_first", n);
        send_byte(8'h20);
        hold0 = tx_data;
        e0 = en_count;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid !== 1'b1 || tx_data !== hold0 || en_count != e0 || rx_ready !== 1'b0)
                errs++;
        end
        chk("t4_stable", 32'(errs), 32'd0);
        chk("t4_tx_data", 32'(tx_data), 32'h89);
        chk("t4_rx_ready", 32'(rx_ready), 32'd0);
        tx_ready = 1'b1;
        wait_txq(q0 + 2, "t4_tx_bytes");
        chk("t4_byte0", 32'(txq[q0]), 32'h89);
        chk("t4_byte1", 32'(txq[q0 + 1]), 32'hB9);
        chk("t4_count", 32'(processed_count), 32'd2);

        // Test 5: rep_ready stall in ISSUE
        do_reset();
        rep_ready = 1'b0;
        tx_ready  = 1'b1;
        send_byte(8'h55);
        n = 0;
        while (!rep_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t5_rep_valid", 32'(rep_valid), 32'd1);
        e0 = en_count;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rep_valid !== 1'b1 || proc_enable !== 1'b0 || rep_data !== 8'h55) errs++;
        end
        chk("t5_stall_hold", 32'(errs), 32'd0);
        chk("t5_no_enable", 32'(en_count - e0), 32'd0);
        rep_ready = 1'b1;
        #1;
        chk("t5_enable_comb", 32'(proc_enable), 32'd1);
        tick();
        chk("t5_rep_valid_clr", 32'(rep_valid), 32'd0);
        chk("t5_one_pulse", 32'(en_count - e0), 32'd1);
        wait_tx_valid("t5_tx_valid", n);
        chk("t5_tx_data", 32'(tx_data), 32'hCC);
        tick();

        // Test 6: 17 bytes with a 4-bit counter
        do_reset();
        rep_ready = 1'b1;
        tx_ready  = 1'b1;
        q0 = txq.size();
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i));
            wait_tx_valid("t6_tx_valid", n);
            tick();
        end
        chk("t6_tx_bytes", 32'(txq.size() - q0), 32'd17);
        chk("t6_last_byte", 32'(txq[q0 + 16]), 32'h89);
        chk("t6_wrapped", 32'(saw_wrap), 32'd1);
        chk("t6_count", 32'(processed_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
